address_generate_pipeline: RTL and testbench

//  Two-stage pipelined x86 address generator for the execute unit, fed by decode/operand fetch.

---
 rtl/address_generate_pipeline.sv | 152 +++++++++++++++
 tb/tb_address_generate_pipeline.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/address_generate_pipeline.sv
// Two-stage x86 address generator: stage 1 forms the effective address, stage 2 forms the
// linear address and checks the segment limit. Valid/ready handshake with a tag per request.
module address_generate_pipeline #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int TAG_WIDTH     = 4,
  parameter bit A20_WRAP      = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  input  logic                     mode_protected,
  input  logic                     address_size_32,
  input  logic                     base_enable,
  input  logic [ADDRESS_WIDTH-1:0] base,
  input  logic                     index_enable,
  input  logic [ADDRESS_WIDTH-1:0] index,
  input  logic [1:0]               scale,
  input  logic [ADDRESS_WIDTH-1:0] displacement,
  input  logic [15:0]              segment_selector,
  input  logic [ADDRESS_WIDTH-1:0] segment_base,
  input  logic [ADDRESS_WIDTH-1:0] segment_limit,
  input  logic [1:0]               access_size,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TAG_WIDTH-1:0]     out_tag,
  output logic [ADDRESS_WIDTH-1:0] effective_address,
  output logic [ADDRESS_WIDTH-1:0] linear_address,
  output logic                     limit_fault
);

  localparam int AW = ADDRESS_WIDTH;
  localparam logic [AW-1:0] A20_MASK   = {{(AW-20){1'b0}}, {20{1'b1}}};
  localparam logic [AW:0]   REAL_LIMIT = {{(AW-15){1'b0}}, {16{1'b1}}};

  logic                 s2_advance, s1_advance, accept;
  logic [AW-1:0]        ea_raw, ea_in;
  logic [AW:0]          end_offset;
  logic [AW-1:0]        real_linear, prot_linear;
  logic                 fault_calc;

  logic                 s1_valid_d, s1_valid_q;
  logic [TAG_WIDTH-1:0] s1_tag_d, s1_tag_q;
  logic [AW-1:0]        s1_ea_d, s1_ea_q;
  logic                 s1_prot_d, s1_prot_q;
  logic [15:0]          s1_sel_d, s1_sel_q;
  logic [AW-1:0]        s1_seg_base_d, s1_seg_base_q;
  logic [AW-1:0]        s1_seg_limit_d, s1_seg_limit_q;
  logic [1:0]           s1_size_d, s1_size_q;

  logic                 out_valid_d, out_valid_q;
  logic [TAG_WIDTH-1:0] out_tag_d, out_tag_q;
  logic [AW-1:0]        out_ea_d, out_ea_q;
  logic [AW-1:0]        out_lin_d, out_lin_q;
  logic                 out_fault_d, out_fault_q;

  // Stage 1: handshake and effective address
  always_comb begin
    s2_advance = !out_valid_q || out_ready;
    s1_advance = s1_valid_q && s2_advance;
    in_ready   = !s1_valid_q || s1_advance;
    accept     = in_valid && in_ready;

    ea_raw = (base_enable ? base : '0)
           + ((index_enable ? index : '0) << scale)
           + displacement;
    ea_in  = address_size_32 ? ea_raw : {{(AW-16){1'b0}}, ea_raw[15:0]};

    s1_valid_d     = s1_valid_q;
    s1_tag_d       = s1_tag_q;
    s1_ea_d        = s1_ea_q;
    s1_prot_d      = s1_prot_q;
    s1_sel_d       = s1_sel_q;
    s1_seg_base_d  = s1_seg_base_q;
    s1_seg_limit_d = s1_seg_limit_q;
    s1_size_d      = s1_size_q;
    if (in_ready) s1_valid_d = in_valid;
    if (accept) begin
      s1_tag_d       = in_tag;
      s1_ea_d        = ea_in;
      s1_prot_d      = mode_protected;
      s1_sel_d       = segment_selector;
      s1_seg_base_d  = segment_base;
      s1_seg_limit_d = segment_limit;
      s1_size_d      = access_size;
    end
  end

  // Stage 2: linear address and limit check; the extra bit keeps EA + size from wrapping
  always_comb begin
    end_offset  = {1'b0, s1_ea_q} + {{(AW-1){1'b0}}, s1_size_q};
    real_linear = AW'({segment_selector_q_ext(s1_sel_q)}) + {{(AW-16){1'b0}}, s1_ea_q[15:0]};
    if (A20_WRAP) real_linear = real_linear & A20_MASK;
    prot_linear = s1_seg_base_q + s1_ea_q;
    fault_calc  = s1_prot_q ? (end_offset > {1'b0, s1_seg_limit_q})
                            : (end_offset > REAL_LIMIT);

    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    out_ea_d    = out_ea_q;
    out_lin_d   = out_lin_q;
    out_fault_d = out_fault_q;
    if (s2_advance) out_valid_d = s1_valid_q;
    if (s1_advance) begin
      out_tag_d   = s1_tag_q;
      out_ea_d    = s1_ea_q;
      out_lin_d   = s1_prot_q ? prot_linear : real_linear;
      out_fault_d = fault_calc;
    end
  end

  function automatic logic [19:0] segment_selector_q_ext(input logic [15:0] sel);
    return {sel, 4'h0};
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_ea_q    <= '0;
      out_lin_q   <= '0;
      out_fault_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_ea_q    <= out_ea_d;
      out_lin_q   <= out_lin_d;
      out_fault_q <= out_fault_d;
    end
  end

  // Stage-1 payload is qualified by s1_valid_q, so it needs no reset
  always_ff @(posedge clock) begin
    s1_tag_q       <= s1_tag_d;
    s1_ea_q        <= s1_ea_d;
    s1_prot_q      <= s1_prot_d;
    s1_sel_q       <= s1_sel_d;
    s1_seg_base_q  <= s1_seg_base_d;
    s1_seg_limit_q <= s1_seg_limit_d;
    s1_size_q      <= s1_size_d;
  end

  assign out_valid         = out_valid_q;
  assign out_tag           = out_tag_q;
  assign effective_address = out_ea_q;
  assign linear_address    = out_lin_q;
  assign limit_fault       = out_fault_q;

endmodule

// File: tb/tb_address_generate_pipeline.sv
// Directed bench for address_generate_pipeline: scoreboard of expected results checked
// on the output handshake, plus directed latency, stall, throughput and reset steps.
module tb_address_generate_pipeline;

  typedef struct {
    logic        prot, as32, be, ie;
    logic [31:0] base, index, disp, sb, lim;
    logic [1:0]  sc, size;
    logic [15:0] sel;
    logic [3:0]  tag;
  } req_t;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] ea, lin;
    logic        fault;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_tag = '0;
  logic        mode_protected = 1'b0, address_size_32 = 1'b0;
  logic        base_enable = 1'b0, index_enable = 1'b0;
  logic [31:0] base = '0, index = '0, displacement = '0;
  logic [1:0]  scale = '0, access_size = '0;
  logic [15:0] segment_selector = '0;
  logic [31:0] segment_base = '0, segment_limit = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_tag;
  logic [31:0] effective_address, linear_address;
  logic        limit_fault;

  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;
  int   ready_mode = 0;
  int   pat_idx = 0;
  exp_t sb_q[$];
  int   pop_cycles[$];

  address_generate_pipeline #(.ADDRESS_WIDTH(32), .TAG_WIDTH(4), .A20_WRAP(1'b1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .mode_protected(mode_protected), .address_size_32(address_size_32),
    .base_enable(base_enable), .base(base), .index_enable(index_enable), .index(index),
    .scale(scale), .displacement(displacement), .segment_selector(segment_selector),
    .segment_base(segment_base), .segment_limit(segment_limit), .access_size(access_size),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .effective_address(effective_address), .linear_address(linear_address),
    .limit_fault(limit_fault)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  // out_ready: 0 = low, 1 = high, 2 = repeating 1,0,0
  always @(posedge clock) begin
    #2;
    case (ready_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: begin
        out_ready = (pat_idx == 0);
        pat_idx = (pat_idx == 2) ? 0 : pat_idx + 1;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input req_t r);
    exp_t        e;
    logic [31:0] b, i, ea;
    logic [32:0] end_off;
    b  = r.be ? r.base : 32'h0;
    i  = r.ie ? r.index : 32'h0;
    ea = b + (i << r.sc) + r.disp;
    if (!r.as32) ea = ea & 32'h0000_FFFF;
    end_off = {1'b0, ea} + {31'h0, r.size};
    if (r.prot) begin
      e.lin   = r.sb + ea;
      e.fault = end_off > {1'b0, r.lim};
    end else begin
      e.lin   = ({12'h0, r.sel, 4'h0} + {16'h0, ea[15:0]}) & 32'h000F_FFFF;
      e.fault = end_off > 33'h0_0000_FFFF;
    end
    e.ea  = ea;
    e.tag = r.tag;
    return e;
  endfunction

  // Output monitor: scoreboard pop on transfer, hold check during stalls
  logic        stall_prev = 1'b0;
  logic [3:0]  h_tag;
  logic [31:0] h_ea, h_lin;
  logic        h_fault;
  always @(negedge clock) begin
    exp_t e;
    if (stall_prev && !reset) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_tag", 64'(out_tag), 64'(h_tag));
      chk("hold_ea", 64'(effective_address), 64'(h_ea));
      chk("hold_lin", 64'(linear_address), 64'(h_lin));
      chk("hold_fault", 64'(limit_fault), 64'(h_fault));
    end
    stall_prev = !reset && out_valid && !out_ready;
    h_tag = out_tag; h_ea = effective_address; h_lin = linear_address; h_fault = limit_fault;
    if (!reset && out_valid && out_ready) begin
      tests++;
      assert (sb_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_out: observed tag %0h expected no output", out_tag);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_tag", 64'(out_tag), 64'(e.tag));
        chk("sb_ea", 64'(effective_address), 64'(e.ea));
        chk("sb_lin", 64'(linear_address), 64'(e.lin));
        chk("sb_fault", 64'(limit_fault), 64'(e.fault));
        pop_cycles.push_back(cycle);
      end
    end
  end

  task automatic drive(input req_t r);
    in_tag = r.tag; mode_protected = r.prot; address_size_32 = r.as32;
    base_enable = r.be; base = r.base; index_enable = r.ie; index = r.index;
    scale = r.sc; displacement = r.disp; segment_selector = r.sel;
    segment_base = r.sb; segment_limit = r.lim; access_size = r.size;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted r.
  task automatic send(input req_t r);
    int n = 0;
    drive(r);
    in_valid = 1'b1;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        tests++; fails++;
        $error("FAIL accept_timeout: observed in_ready 0 expected 1 within 200 cycles");
        break;
      end
    end
    if (n <= 200) sb_q.push_back(model(r));
    @(posedge clock); #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (sb_q.size() != 0 && n < 500) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!out_valid && n < 20);
    chk(tag, 64'(out_valid), 64'd1);
  endtask

  function automatic req_t mk(input logic prot, as32, be, input logic [31:0] b,
                              input logic ie, input logic [31:0] i, input logic [1:0] sc,
                              input logic [31:0] d, input logic [15:0] sel,
                              input logic [31:0] sbase, lim, input logic [1:0] sz,
                              input logic [3:0] tag);
    req_t r;
    r.prot = prot; r.as32 = as32; r.be = be; r.base = b; r.ie = ie; r.index = i;
    r.sc = sc; r.disp = d; r.sel = sel; r.sb = sbase; r.lim = lim; r.size = sz; r.tag = tag;
    return r;
  endfunction

  function automatic req_t rnd(input logic [3:0] tag);
    req_t r;
    r.prot = 1'($urandom_range(0, 1)); r.as32 = 1'($urandom_range(0, 1));
    r.be = 1'($urandom_range(0, 1));   r.ie = 1'($urandom_range(0, 1));
    r.base = $urandom; r.index = $urandom; r.disp = $urandom; r.sb = $urandom;
    r.lim = 32'($urandom_range(0, 32'h0003_0000));
    r.sc = 2'($urandom_range(0, 3)); r.size = 2'($urandom_range(0, 3));
    r.sel = 16'($urandom); r.tag = tag;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    // Reset with a request presented: must not be accepted
    ready_mode = 1;
    drive(mk(1, 1, 1, 32'h55, 0, 0, 0, 0, 0, 0, 32'hFFFF, 0, 4'hF));
    in_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_ea", 64'(effective_address), 64'd0);
    chk("rst_lin", 64'(linear_address), 64'd0);
    chk("rst_fault", 64'(limit_fault), 64'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("rst_no_accept", 64'(out_valid), 64'd0);

    // Protected mode, 2-cycle latency
    send(mk(1, 1, 1, 32'h1000, 1, 32'h10, 2, 32'h4, 0, 32'h20000, 32'hFFFF, 3, 4'h1));
    in_valid = 1'b0;
    @(negedge clock);
    chk("t1_lat_early", 64'(out_valid), 64'd0);
    @(negedge clock);
    chk("t1_lat_valid", 64'(out_valid), 64'd1);
    chk("t1_ea", 64'(effective_address), 64'h1044);
    chk("t1_lin", 64'(linear_address), 64'h21044);
    chk("t1_fault", 64'(limit_fault), 64'd0);
    @(posedge clock); #1;
    drain();

    // Real mode, A20 wrap
    send(mk(0, 0, 1, 32'h0010, 0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 4'h2));
    in_valid = 1'b0;
    wait_out("t2_valid");
    chk("t2_ea", 64'(effective_address), 64'h0010);
    chk("t2_lin", 64'(linear_address), 64'h0);
    chk("t2_fault", 64'(limit_fault), 64'd0);
    @(posedge clock); #1;
    drain();

    // 16-bit silent wrap
    send(mk(1, 0, 1, 32'hFFFF, 0, 0, 0, 32'h2, 0, 32'h0, 32'hFFFF, 0, 4'h3));
    in_valid = 1'b0;
    wait_out("t3a_valid");
    chk("t3a_ea", 64'(effective_address), 64'h0001);
    chk("t3a_fault", 64'(limit_fault), 64'd0);
    @(posedge clock); #1;
    drain();

    // Limit fault with address still produced
    send(mk(1, 1, 1, 32'hFFFE, 0, 0, 0, 0, 0, 32'h100, 32'hFFFF, 3, 4'h4));
    in_valid = 1'b0;
    wait_out("t3b_valid");
    chk("t3b_fault", 64'(limit_fault), 64'd1);
    chk("t3b_lin", 64'(linear_address), 64'h100FE);
    @(posedge clock); #1;
    drain();

    // More limit boundaries, scoreboard only
    send(mk(1, 1, 1, 32'hFFFE, 0, 0, 0, 0, 0, 0, 32'hFFFF, 1, 4'h5));
    send(mk(1, 1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 3, 4'h6));
    send(mk(0, 0, 1, 32'hFFFF, 0, 0, 0, 0, 16'h1234, 0, 0, 1, 4'h7));
    send(mk(0, 1, 1, 32'h0001_0000, 1, 32'h3, 3, 32'hFFFF_FFF0, 16'h0100, 0, 0, 0, 4'h8));
    drain();

    // Full pipeline with consumer stalled
    ready_mode = 0;
    send(rnd(4'h9));
    send(rnd(4'hA));
    in_valid = 1'b0;
    @(negedge clock);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    repeat (3) @(posedge clock);
    #1;
    ready_mode = 1;
    drain();

    // Six tagged requests with toggling out_ready
    ready_mode = 2;
    for (int t = 0; t < 6; t++) begin
      r = rnd(4'(t));
      send(r);
    end
    drain();

    // Back-to-back throughput
    ready_mode = 1;
    @(posedge clock); #1;
    pop_cycles.delete();
    for (int t = 0; t < 8; t++) begin
      r = rnd(4'(t + 8));
      send(r);
    end
    drain();
    chk("tput_count", 64'(pop_cycles.size()), 64'd8);
    if (pop_cycles.size() == 8)
      chk("tput_span", 64'(pop_cycles[7] - pop_cycles[0]), 64'd7);

    // Reset with two requests in flight
    send(rnd(4'hC));
    send(rnd(4'hD));
    in_valid = 1'b0;
    ready_mode = 0;
    reset = 1'b1;
    sb_q.delete();
    @(posedge clock); #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    ready_mode = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("midrst_no_stale", 64'(out_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
